// File: rtl/i2s_tdm_xmit.sv
// I2S / left-justified / TDM serial transmitter.
// A frame word (all channels) is staged in a one-deep holding register and
// moved into a padded frame shifter on each falling lrclk edge. Bits leave
// MSB-first on BCLK falling-edge strobes. Each channel slot is the data word
// followed by zero padding.
module i2s_tdm_xmit #(
  parameter int DATA_BITS = 24,
  parameter int SLOT_BITS = 32,
  parameter int NUM_CH    = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        lrclk,
  input  logic                        CBrise,
  input  logic                        CBfall,
  input  logic                        mode,
  input  logic [NUM_CH*DATA_BITS-1:0] sample_data,
  input  logic                        sample_valid,
  output logic                        sample_ready,
  output logic                        outbit,
  output logic                        underflow,
  output logic                        frame_err
);

  localparam int FRAME_BITS = NUM_CH * SLOT_BITS;
  localparam int CNT_W      = $clog2(FRAME_BITS + 2);
  localparam int WORD_BITS  = NUM_CH * DATA_BITS;

  // Last counter position carrying data: I2S spends position 0 on the delay bit.
  localparam logic [CNT_W-1:0] LAST_I2S = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] LAST_LJ  = CNT_W'(FRAME_BITS - 1);

  typedef enum logic [1:0] {IDLE, SEND, PAD} state_t;

  state_t                  state_reg, state_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic [FRAME_BITS-1:0]   shift_reg, shift_next;
  logic [WORD_BITS-1:0]    hold_reg, hold_next;
  logic                    full_reg, full_next;
  logic                    mode_reg, mode_next;
  logic                    outbit_reg, outbit_next;
  logic                    underflow_reg, underflow_next;
  logic                    frame_err_reg, frame_err_next;
  logic                    lrclk_d_reg;

  logic                    frame_edge;
  logic                    accept;
  logic                    mode_sel;
  logic [CNT_W-1:0]        cur_pos;
  logic [CNT_W-1:0]        last_pos;
  logic [WORD_BITS-1:0]    src_word;
  logic [FRAME_BITS-1:0]   load_frame;
  logic [FRAME_BITS-1:0]   shift_src;

  // CBrise marks the receiver's sampling point; the transmitter ignores it.
  logic cbrise_unused;
  assign cbrise_unused = CBrise;

  assign frame_edge   = lrclk_d_reg && !lrclk;
  assign sample_ready = !full_reg && !rst;
  assign accept       = sample_valid && sample_ready;

  // Word for the next frame: held word first, else bypass, else silence.
  assign src_word = full_reg ? hold_reg : (sample_valid ? sample_data : '0);

  // On the edge clk the new frame's mode and bit 0 take effect immediately.
  assign mode_sel  = frame_edge ? mode : mode_reg;
  assign cur_pos   = frame_edge ? '0 : cnt_reg;
  assign last_pos  = mode_sel ? LAST_LJ : LAST_I2S;
  assign shift_src = frame_edge ? load_frame : shift_reg;

  // Lay each channel word into its slot, MSB-aligned, zero padded below.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_slot
      if (SLOT_BITS > DATA_BITS) begin : g_pad
        assign load_frame[(NUM_CH-gi)*SLOT_BITS-1 -: SLOT_BITS] =
          {src_word[(NUM_CH-gi)*DATA_BITS-1 -: DATA_BITS], {(SLOT_BITS-DATA_BITS){1'b0}}};
      end else begin : g_nopad
        assign load_frame[(NUM_CH-gi)*SLOT_BITS-1 -: SLOT_BITS] =
          src_word[(NUM_CH-gi)*DATA_BITS-1 -: DATA_BITS];
      end
    end
  endgenerate

  // Next-state and datapath: frame-edge loading, holding-register handshake, bit emission.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    shift_next     = shift_reg;
    hold_next      = hold_reg;
    full_next      = full_reg;
    mode_next      = mode_reg;
    outbit_next    = outbit_reg;
    underflow_next = 1'b0;
    frame_err_next = 1'b0;

    if (frame_edge) begin
      full_next      = 1'b0;
      mode_next      = mode;
      state_next     = SEND;
      cnt_next       = '0;
      shift_next     = load_frame;
      underflow_next = !full_reg && !sample_valid;
      frame_err_next = (state_reg == SEND);
    end else if (accept) begin
      full_next = 1'b1;
      hold_next = sample_data;
    end

    if (CBfall) begin
      if (frame_edge || state_reg == SEND) begin
        if (!mode_sel && cur_pos == '0) begin
          outbit_next = 1'b0;
        end else begin
          outbit_next = shift_src[FRAME_BITS-1];
          shift_next  = shift_src << 1;
        end
        cnt_next = cur_pos + 1'b1;
        if (cur_pos == last_pos) begin
          state_next = PAD;
        end
      end else begin
        outbit_next = 1'b0;
      end
    end
  end

  // State and datapath registers; reset drops the frame and any held word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      shift_reg     <= '0;
      hold_reg      <= '0;
      full_reg      <= 1'b0;
      mode_reg      <= 1'b0;
      outbit_reg    <= 1'b0;
      underflow_reg <= 1'b0;
      frame_err_reg <= 1'b0;
      lrclk_d_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      shift_reg     <= shift_next;
      hold_reg      <= hold_next;
      full_reg      <= full_next;
      mode_reg      <= mode_next;
      outbit_reg    <= outbit_next;
      underflow_reg <= underflow_next;
      frame_err_reg <= frame_err_next;
      lrclk_d_reg   <= lrclk;
    end
  end

  assign outbit    = outbit_reg;
  assign underflow = underflow_reg;
  assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_i2s_tdm_xmit.sv
// Testbench for i2s_tdm_xmit: a stereo 24/32 instance and a 4-slot 16/16 TDM
// instance share clocks, lrclk and strobes. Expected serial bits are queued per
// frame and popped on every CBfall.
module tb_i2s_tdm_xmit;

  localparam logic [63:0] WA  = {16'h0000, 24'hA5A5A5, 24'h5A5A5A};
  localparam logic [63:0] WB  = {16'h8001, 16'h0002, 16'h0004, 16'hFFFF};
  localparam logic [63:0] W2A = {16'h0000, 24'h123456, 24'hFEDCBA};
  localparam logic [63:0] W2B = {16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
  localparam logic [63:0] BA  = {16'h0000, 24'hC3C3C3, 24'h0F0F0F};
  localparam logic [63:0] BB  = {16'hAAAA, 16'h5555, 16'h00FF, 16'hFF00};
  localparam int FRAME_LEN = 68;

  logic clk = 1'b0;
  logic rst, lrclk, cbrise, cbfall, mode, valid;
  logic [47:0] data_a;
  logic [63:0] data_b;
  logic ready_a, out_a, uf_a, fe_a;
  logic ready_b, out_b, uf_b, fe_b;

  always #5 clk = ~clk;

  i2s_tdm_xmit u_dut_a (
    .clk(clk), .rst(rst), .lrclk(lrclk), .CBrise(cbrise), .CBfall(cbfall),
    .mode(mode), .sample_data(data_a), .sample_valid(valid),
    .sample_ready(ready_a), .outbit(out_a), .underflow(uf_a), .frame_err(fe_a)
  );

  i2s_tdm_xmit #(.DATA_BITS(16), .SLOT_BITS(16), .NUM_CH(4)) u_dut_b (
    .clk(clk), .rst(rst), .lrclk(lrclk), .CBrise(cbrise), .CBfall(cbfall),
    .mode(mode), .sample_data(data_b), .sample_valid(valid),
    .sample_ready(ready_b), .outbit(out_b), .underflow(uf_b), .frame_err(fe_b)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic qa[$];
  logic qb[$];
  logic last_a = 1'b0;
  logic last_b = 1'b0;
  int uf_cnt_a, uf_cnt_b, fe_cnt_a, fe_cnt_b;
  logic held_valid;
  logic [63:0] held_a, held_b;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference bit at frame position pos: channel 0 sits in the word MSBs.
  function automatic logic exp_bit(input logic [63:0] fw, input int nch, input int sb,
                                   input int db, input logic md, input int pos);
    int d, k, b;
    d = md ? pos : pos - 1;
    if (d < 0 || d >= nch * sb) return 1'b0;
    k = d / sb;
    b = d % sb;
    if (b >= db) return 1'b0;
    return fw[(nch - k) * db - 1 - b];
  endfunction

  // One clk: drive strobes/lrclk, then check outbit holds the last expected bit.
  task automatic step(input logic fall, input logic rise, input logic lr);
    cbfall = fall;
    cbrise = rise;
    lrclk  = lr;
    @(posedge clk);
    #1;
    if (rst) begin
      last_a = 1'b0;
      last_b = 1'b0;
    end else if (fall) begin
      last_a = (qa.size() > 0) ? qa.pop_front() : 1'b0;
      last_b = (qb.size() > 0) ? qb.pop_front() : 1'b0;
    end
    check_eq("outbit_a", 64'(out_a), 64'(last_a));
    check_eq("outbit_b", 64'(out_b), 64'(last_b));
    if (uf_a) uf_cnt_a++;
    if (uf_b) uf_cnt_b++;
    if (fe_a) fe_cnt_a++;
    if (fe_b) fe_cnt_b++;
  endtask

  task automatic bit_period(input logic lr);
    step(1'b1, 1'b0, lr);
    step(1'b0, 1'b0, lr);
    step(1'b0, 1'b1, lr);
    step(1'b0, 1'b0, lr);
  endtask

  task automatic offer(input logic [63:0] wa, input logic [63:0] wb, input logic lr);
    valid  = 1'b1;
    data_a = wa[47:0];
    data_b = wb;
    step(1'b0, 1'b0, lr);
    valid = 1'b0;
    held_valid = 1'b1;
    held_a = wa;
    held_b = wb;
    check_eq("ready_a_full", 64'(ready_a), 64'd0);
    check_eq("ready_b_full", 64'(ready_b), 64'd0);
  endtask

  // Frame starting with an edge coincident with CBfall; src 1 offers a bypass word on the edge clk.
  task automatic run_frame(input int src, input int nbits, input logic exp_fe, input logic flip,
                           input logic [63:0] bw_a, input logic [63:0] bw_b);
    logic [63:0] fa, fb;
    logic exp_uf;
    if (held_valid) begin
      fa = held_a; fb = held_b; exp_uf = 1'b0;
    end else if (src == 1) begin
      fa = bw_a; fb = bw_b; exp_uf = 1'b0;
    end else begin
      fa = '0; fb = '0; exp_uf = 1'b1;
    end
    held_valid = 1'b0;
    qa.delete();
    qb.delete();
    for (int p = 0; p < FRAME_LEN; p++) begin
      qa.push_back(exp_bit(fa, 2, 32, 24, mode, p));
      qb.push_back(exp_bit(fb, 4, 16, 16, mode, p));
    end
    uf_cnt_a = 0; uf_cnt_b = 0; fe_cnt_a = 0; fe_cnt_b = 0;
    if (src == 1) begin
      valid  = 1'b1;
      data_a = bw_a[47:0];
      data_b = bw_b;
    end
    step(1'b1, 1'b0, 1'b0);
    valid = 1'b0;
    check_eq("ready_a_after_edge", 64'(ready_a), 64'd1);
    check_eq("ready_b_after_edge", 64'(ready_b), 64'd1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    for (int i = 1; i < nbits; i++) begin
      if (flip && i == 30) mode = ~mode;
      bit_period(i >= FRAME_LEN / 2);
    end
    check_eq("underflow_a_clks", 64'(uf_cnt_a), 64'(exp_uf));
    check_eq("underflow_b_clks", 64'(uf_cnt_b), 64'(exp_uf));
    check_eq("frame_err_a_clks", 64'(fe_cnt_a), 64'(exp_fe));
    check_eq("frame_err_b_clks", 64'(fe_cnt_b), 64'(exp_fe));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; lrclk = 1'b0; cbrise = 1'b0; cbfall = 1'b0; mode = 1'b0;
    valid = 1'b0; data_a = '0; data_b = '0; held_valid = 1'b0;
    held_a = '0; held_b = '0;
    uf_cnt_a = 0; uf_cnt_b = 0; fe_cnt_a = 0; fe_cnt_b = 0;

    // Reset state
    repeat (3) step(1'b0, 1'b0, 1'b0);
    check_eq("ready_a_rst", 64'(ready_a), 64'd0);
    check_eq("underflow_a_rst", 64'(uf_a), 64'd0);
    check_eq("frame_err_a_rst", 64'(fe_a), 64'd0);
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    check_eq("ready_a_post_rst", 64'(ready_a), 64'd1);
    check_eq("ready_b_post_rst", 64'(ready_b), 64'd1);

    // Idle before the first frame edge: zeros
    repeat (3) bit_period(1'b1);

    // I2S frame from the holding register
    offer(WA, WB, 1'b1);
    run_frame(0, FRAME_LEN, 1'b0, 1'b0, '0, '0);

    // Left-justified frame; mode flips mid-frame without effect
    offer(WA, WB, 1'b1);
    mode = 1'b1;
    run_frame(0, FRAME_LEN, 1'b0, 1'b1, '0, '0);

    // No word at the edge: underflow and silent frame (mode back to I2S)
    run_frame(0, FRAME_LEN, 1'b0, 1'b0, '0, '0);

    // Bypass: valid on the edge clk with an empty holding register
    run_frame(1, FRAME_LEN, 1'b0, 1'b0, BA, BB);

    // Early frame edge after 10 data bits: resync
    offer(WA, WB, 1'b1);
    run_frame(0, 11, 1'b0, 1'b0, '0, '0);
    offer(W2A, W2B, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    run_frame(0, FRAME_LEN, 1'b1, 1'b0, '0, '0);

    // Reset mid-frame with a word held
    offer(WA, WB, 1'b1);
    run_frame(0, 20, 1'b0, 1'b0, '0, '0);
    offer(W2A, W2B, 1'b0);
    rst = 1'b1;
    repeat (2) begin
      step(1'b1, 1'b0, 1'b0);
      check_eq("ready_a_in_rst", 64'(ready_a), 64'd0);
      check_eq("ready_b_in_rst", 64'(ready_b), 64'd0);
    end
    rst = 1'b0;
    held_valid = 1'b0;
    qa.delete();
    qb.delete();
    step(1'b0, 1'b0, 1'b1);
    check_eq("ready_a_after_rst", 64'(ready_a), 64'd1);
    check_eq("ready_b_after_rst", 64'(ready_b), 64'd1);
    repeat (3) bit_period(1'b1);
    run_frame(0, FRAME_LEN, 1'b0, 1'b0, '0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
